mem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 32-bit word memory (15-bit word address, combinational read, write on clock edge, rw=0 means write) between the CPU (master 0) and a second requester (master 1, DMA/loader). Grants the memory to one master at a time using round-robin priority and a bounded hold time. Performs at most one access per cycle and returns registered read data with a one-cycle ack.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_rr_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-master memory arbiter.
// The request bundle groups one master's request, address, write data and direction.
package mem_arb_pkg;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_ADDR_W = 16;
  localparam int ARB_MEM_AW = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  req;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  rw;
  } mem_req_t;
endpackage

// File: rtl/arb_rr_pick.sv
// Next-owner selector: round-robin pointer breaks ties from IDLE; a hold limit preempts only under contention.
// Purely combinational, no latency; a master that drops req releases ownership at once.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  input  arb_state_t state,
  input  logic       hold_expired,
  output arb_state_t next
);

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  next = ptr ? OWN1 : OWN0;
        else if (req0)     next = OWN0;
        else if (req1)     next = OWN1;
        else               next = IDLE;
      end
      OWN0: begin
        if (!req0)                     next = req1 ? OWN1 : IDLE;
        else if (req1 && hold_expired) next = OWN1;
      end
      OWN1: begin
        if (!req1)                     next = req0 ? OWN0 : IDLE;
        else if (req0 && hold_expired) next = OWN0;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between two masters; one access per granted req cycle.
// Grant follows req by one cycle; read data and ack are registered one cycle after the access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = ARB_DATA_W,
  parameter int ADDR_W   = ARB_ADDR_W,
  parameter int MEM_AW   = ARB_MEM_AW,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_rw,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_rw,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rw
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t        state, next_state;
  logic              ptr;
  logic [HW-1:0]     hold_cnt;
  mem_req_t          m0, m1, cur;
  logic              acc, oor;
  logic [DATA_W-1:0] rd_dat;

  assign m0 = '{req: m0_req, addr: m0_addr, wdata: m0_wdata, rw: m0_rw};
  assign m1 = '{req: m1_req, addr: m1_addr, wdata: m1_wdata, rw: m1_rw};

  always_comb begin
    cur = m0;
    if (state == OWN1) cur = m1;
  end

  assign acc    = (state == OWN0 || state == OWN1) && cur.req;
  // Top address bit maps to empty space: writes are dropped, reads return zero.
  assign oor    = cur.addr[ADDR_W-1];
  assign rd_dat = oor ? '0 : mem_rdata;

  assign mem_addr  = acc ? cur.addr[MEM_AW-1:0] : '0;
  assign mem_wdata = acc ? cur.wdata : '0;
  assign mem_rw    = (!rst || !acc || oor) ? 1'b1 : cur.rw;

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);

  arb_rr_pick u_pick (
    .req0         (m0_req),
    .req1         (m1_req),
    .ptr          (ptr),
    .state        (state),
    .hold_expired (hold_cnt == HOLD_LAST),
    .next         (next_state)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      hold_cnt <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state  <= next_state;
      m0_ack <= acc && (state == OWN0);
      m1_ack <= acc && (state == OWN1);
      if (acc && cur.rw) begin
        if (state == OWN0) m0_rdata <= rd_dat;
        else               m1_rdata <= rd_dat;
      end
      // Any ownership change restarts the hold window; leaving an owner hands priority to the other.
      if (next_state != state) begin
        hold_cnt <= '0;
        if (state == OWN0)      ptr <= 1'b1;
        else if (state == OWN1) ptr <= 1'b0;
      end else if (acc && hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench with a read-data scoreboard and a behavioural memory for mem_arbiter (MAX_HOLD=4).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_rw;

  logic [31:0] mem     [0:32767];
  logic [31:0] ref_mem [0:32767];
  logic [31:0] last_rd [2];
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          ack_cnt0 = 0;
  int          ack_cnt1 = 0;
  int          lat;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rw(mem_rw)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (!mem_rw) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one access: returns the rdata value the master should hold after its ack.
  task automatic model_access(input int m, input logic [15:0] a, input logic rw,
                              input logic [31:0] wd, output logic [31:0] exp);
    if (rw) last_rd[m] = a[15] ? 32'h0 : ref_mem[a[14:0]];
    else if (!a[15]) ref_mem[a[14:0]] = wd;
    exp = last_rd[m];
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (m0_ack) begin
      ack_cnt0++;
      if (q0.size() == 0) check("m0_ack_unexpected", 32'd1, 32'd0);
      else begin e = q0.pop_front(); check("m0_rdata", m0_rdata, e); end
    end
    if (m1_ack) begin
      ack_cnt1++;
      if (q1.size() == 0) check("m1_ack_unexpected", 32'd1, 32'd0);
      else begin e = q1.pop_front(); check("m1_rdata", m1_rdata, e); end
    end
    if (!rst) begin
      q0.delete(); q1.delete();
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    end else begin
      if (m0_gnt && m0_req) begin model_access(0, m0_addr, m0_rw, m0_wdata, e); q0.push_back(e); end
      if (m1_gnt && m1_req) begin model_access(1, m1_addr, m1_rw, m1_wdata, e); q1.push_back(e); end
    end
  end

  // Single access from IDLE: raise req, wait for grant, keep req through the access cycle, drop on ack.
  task automatic do_access(input int m, input logic [15:0] a, input logic rw,
                           input logic [31:0] wd, output int cycles);
    logic g;
    if (m == 0) begin m0_req = 1; m0_addr = a; m0_rw = rw; m0_wdata = wd; end
    else        begin m1_req = 1; m1_addr = a; m1_rw = rw; m1_wdata = wd; end
    cycles = 0;
    do begin
      tick();
      cycles++;
      g = (m == 0) ? m0_gnt : m1_gnt;
    end while (!g && cycles < 20);
    check("gnt", 32'(g), 32'd1);
    check("other_gnt", 32'((m == 0) ? m1_gnt : m0_gnt), 32'd0);
    check("mem_rw", 32'(mem_rw), 32'(a[15] | rw));
    check("mem_addr", 32'(mem_addr), 32'(a[14:0]));
    tick();
    check("ack", 32'((m == 0) ? m0_ack : m1_ack), 32'd1);
    m0_req = 0;
    m1_req = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 0;
    m0_req = 0; m0_rw = 1; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_rw = 1; m1_addr = '0; m1_wdata = '0;

    // Reset held with a pending write: nothing granted, memory never written.
    m0_req = 1; m0_rw = 0; m0_addr = 16'h0020; m0_wdata = 32'h000000A5;
    repeat (3) begin
      tick();
      check("rst_gnt0", 32'(m0_gnt), 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd1);
    end
    check("rst_ack0", 32'(m0_ack), 32'd0);
    check("rst_gnt1", 32'(m1_gnt), 32'd0);
    check("rst_rdata0", m0_rdata, 32'h0);
    rst = 1;
    do_access(0, 16'h0020, 1'b0, 32'h000000A5, lat);
    check("t1_latency", 32'(lat), 32'd1);
    check("t1_mem", mem[32], 32'h000000A5);

    // Write then read back through master 0.
    do_access(0, 16'h0010, 1'b0, 32'hDEADBEEF, lat);
    do_access(0, 16'h0010, 1'b1, 32'h0, lat);
    check("t2_rdata", m0_rdata, 32'hDEADBEEF);
    check("t2_gnt1", 32'(m1_gnt), 32'd0);

    // Contention from reset: m0 first, then 4-cycle windows alternating.
    rst = 0; tick(); tick();
    rst = 1;
    m0_req = 1; m0_rw = 1; m0_addr = 16'h0010;
    m1_req = 1; m1_rw = 1; m1_addr = 16'h0020;
    tick();
    ack_cnt0 = 0; ack_cnt1 = 0;
    for (int i = 0; i < 16; i++) begin
      check("t3_gnt", 32'({m1_gnt, m0_gnt}), ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    m0_req = 0; m1_req = 0;
    tick();
    check("t3_acks0", 32'(ack_cnt0), 32'd8);
    check("t3_acks1", 32'(ack_cnt1), 32'd8);

    // Direct handover m0 -> m1, then pointer returns priority to m0.
    m0_req = 1; m0_rw = 0; m0_addr = 16'h0030; m0_wdata = 32'h00000030;
    tick();
    check("t4_gnt0", 32'(m0_gnt), 32'd1);
    tick();
    check("t4_ack0", 32'(m0_ack), 32'd1);
    m0_req = 0; m1_req = 1; m1_rw = 1; m1_addr = 16'h0030;
    tick();
    check("t4_handover", 32'({m1_gnt, m0_gnt}), 32'd2);
    tick();
    check("t4_ack1", 32'(m1_ack), 32'd1);
    m1_req = 0;
    tick();
    check("t4_idle", 32'({m1_gnt, m0_gnt}), 32'd0);
    m0_req = 1; m0_rw = 1; m1_req = 1;
    tick();
    check("t4_ptr", 32'({m1_gnt, m0_gnt}), 32'd1);
    m0_req = 0; m1_req = 0;
    tick();

    // Out-of-range space: write dropped, read returns zero.
    do_access(1, 16'h8010, 1'b0, 32'h12345678, lat);
    check("t5_mem", mem[16], 32'hDEADBEEF);
    do_access(1, 16'h8010, 1'b1, 32'h0, lat);
    check("t5_rdata", m1_rdata, 32'h0);

    // Reset during an m1 read burst.
    m1_req = 1; m1_rw = 1; m1_addr = 16'h0020;
    lat = 0;
    do begin tick(); lat++; end while (!m1_gnt && lat < 20);
    check("t6_gnt1", 32'(m1_gnt), 32'd1);
    tick();
    rst = 0;
    tick();
    check("t6_rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    check("t6_rst_ack1", 32'(m1_ack), 32'd0);
    rst = 1;
    m0_req = 1; m0_rw = 1; m0_addr = 16'h0010;
    tick();
    check("t6_gnt0", 32'({m1_gnt, m0_gnt}), 32'd1);
    m0_req = 0; m1_req = 0;
    tick(); tick();
    check("q_drain", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
